maze_query_arbiter: RTL

//  Shares the single-port maze tile ROM between pacman and the ghosts. Each requester posts its centre (X,Y) and

---
 rtl/maze_query_if.sv | 46 ++++
 rtl/maze_query_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_query_if.sv
`default_nettype none
// ============================================================================
// Module      : maze_query_if
// Description : Bundle between the movers (requesters), the shared tile ROM
//               and the maze query arbiter.
//               master : requesters + ROM side (drives req/coords/rom_data)
//               slave  : arbiter side (drives rom_addr/rom_rd/done/busy/map*)
//   req      N_REQ      per-requester level request
//   reqX/Y/S N_REQ*10   packed centre X, centre Y, half-size (slice i = [10i+9:10i])
//   rom_addr ADDR_W     tile ROM address
//   rom_rd   1          ROM read enable (data valid one cycle later)
//   rom_data 5          tile code from ROM
//   done     N_REQ      one-hot completion pulse
//   busy     1          arbiter not idle
//   mapL/R/B/T 5        probe results of the last completed query
// Revision    : 1.0 - initial release
// ============================================================================
interface maze_query_if #(
  parameter int N_REQ  = 5,
  parameter int ADDR_W = 12
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*10-1:0] reqX;
  logic [N_REQ*10-1:0] reqY;
  logic [N_REQ*10-1:0] reqS;
  logic [ADDR_W-1:0]   rom_addr;
  logic                rom_rd;
  logic [4:0]          rom_data;
  logic [N_REQ-1:0]    done;
  logic                busy;
  logic [4:0]          mapL;
  logic [4:0]          mapR;
  logic [4:0]          mapB;
  logic [4:0]          mapT;

  modport master (
    output req, reqX, reqY, reqS, rom_data,
    input  rom_addr, rom_rd, done, busy, mapL, mapR, mapB, mapT
  );

  modport slave (
    input  req, reqX, reqY, reqS, rom_data,
    output rom_addr, rom_rd, done, busy, mapL, mapR, mapB, mapT
  );
endinterface
`default_nettype wire

// File: rtl/maze_query_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : maze_query_arbiter
// Description : Round-robin arbiter sharing the single-port maze tile ROM.
//               A granted requester's centre/half-size is latched, then four
//               probe tiles (left, right, below, above) are read on a fixed
//               7-cycle schedule and returned on mapL/mapR/mapB/mapT.
//   Clk      in   system clock, all state on posedge
//   Reset    in   synchronous, active-high
//   bus      slave modport of maze_query_if (requests, ROM port, results)
// Revision    : 1.0 - initial release
// ============================================================================
module maze_query_arbiter #(
  parameter int         N_REQ      = 5,
  parameter int         MAP_COLS   = 50,
  parameter int         MAP_ROWS   = 56,
  parameter int         TILE_SHIFT = 3,
  parameter int         ADDR_W     = 12,
  parameter logic [4:0] OOB_CODE   = 5'h1F
) (
  input  logic         Clk,
  input  logic         Reset,
  maze_query_if.slave  bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_L  = 3'd1;
  localparam logic [2:0] S_RD_R  = 3'd2;
  localparam logic [2:0] S_RD_B  = 3'd3;
  localparam logic [2:0] S_RD_T  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // --------------------------------------------------------------------------
  // Unpacked view of the per-requester coordinates
  // --------------------------------------------------------------------------
  logic [9:0] req_x [N_REQ];
  logic [9:0] req_y [N_REQ];
  logic [9:0] req_s [N_REQ];

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign req_x[i] = bus.reqX[10*i +: 10];
      assign req_y[i] = bus.reqY[10*i +: 10];
      assign req_s[i] = bus.reqS[10*i +: 10];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;        // last grantee; also the current one
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic [9:0]       s_q, s_d;
  logic             oob_q, oob_d;        // previous slot was out of the maze
  logic [4:0]       stage_l_q, stage_l_d;
  logic [4:0]       stage_r_q, stage_r_d;
  logic [4:0]       stage_b_q, stage_b_d;
  logic [4:0]       map_l_q, map_l_d;
  logic [4:0]       map_r_q, map_r_d;
  logic [4:0]       map_b_q, map_b_d;
  logic [4:0]       map_t_q, map_t_d;

  // --------------------------------------------------------------------------
  // Round-robin pick: first set request starting just above the last grantee
  // --------------------------------------------------------------------------
  logic             found;
  logic [IDX_W-1:0] pick_idx;

  always_comb begin : p_pick
    int idx;
    idx      = 0;
    found    = 1'b0;
    pick_idx = ptr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && bus.req[idx]) begin
        found    = 1'b1;
        pick_idx = IDX_W'(idx);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Probe geometry. 12-bit signed arithmetic so that X+S+1 never wraps and a
  // negative coordinate is visible in the sign bit.
  // --------------------------------------------------------------------------
  logic signed [11:0] xs, ys, ss, px, py;
  logic [11:0]        px_u, py_u;
  logic [31:0]        col_w, row_w;
  logic               probe_active;
  logic               probe_oob;

  always_comb begin
    xs = $signed({2'b00, x_q});
    ys = $signed({2'b00, y_q});
    ss = $signed({2'b00, s_q});
    px = xs;
    py = ys;
    probe_active = 1'b1;
    case (state_q)
      S_RD_L:  px = xs - ss - 12'sd1;
      S_RD_R:  px = xs + ss + 12'sd1;
      S_RD_B:  py = ys + ss + 12'sd1;
      S_RD_T:  py = ys - ss - 12'sd1;
      default: probe_active = 1'b0;
    endcase
    px_u      = px;
    py_u      = py;
    col_w     = 32'(px_u >> TILE_SHIFT);
    row_w     = 32'(py_u >> TILE_SHIFT);
    probe_oob = px[11] | py[11] |
                (col_w >= 32'(MAP_COLS)) | (row_w >= 32'(MAP_ROWS));
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state (fixed schedule once granted)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_RD_L;
      S_RD_L:  state_d = S_RD_R;
      S_RD_R:  state_d = S_RD_B;
      S_RD_B:  state_d = S_RD_T;
      S_RD_T:  state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.busy     = (state_q != S_IDLE);
    bus.rom_rd   = probe_active && !probe_oob;
    bus.rom_addr = '0;
    if (bus.rom_rd) begin
      bus.rom_addr = ADDR_W'(row_w * 32'(MAP_COLS) + col_w);
    end
    for (int i = 0; i < N_REQ; i++) begin
      bus.done[i] = (state_q == S_DONE) && (ptr_q == IDX_W'(i));
    end
  end

  assign bus.mapL = map_l_q;
  assign bus.mapR = map_r_q;
  assign bus.mapB = map_b_q;
  assign bus.mapT = map_t_q;

  // --------------------------------------------------------------------------
  // Datapath next-state: grant latch and result capture
  // --------------------------------------------------------------------------
  logic [4:0] slot_code;

  always_comb begin
    ptr_d     = ptr_q;
    x_d       = x_q;
    y_d       = y_q;
    s_d       = s_q;
    stage_l_d = stage_l_q;
    stage_r_d = stage_r_q;
    stage_b_d = stage_b_q;
    map_l_d   = map_l_q;
    map_r_d   = map_r_q;
    map_b_d   = map_b_q;
    map_t_d   = map_t_q;

    // Data returned this cycle belongs to the probe issued last cycle.
    oob_d     = probe_active & probe_oob;
    slot_code = oob_q ? OOB_CODE : bus.rom_data;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          ptr_d = pick_idx;
          for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
              x_d = req_x[i];
              y_d = req_y[i];
              s_d = req_s[i];
            end
          end
        end
      end
      S_RD_R: stage_l_d = slot_code;
      S_RD_B: stage_r_d = slot_code;
      S_RD_T: stage_b_d = slot_code;
      // Commit all four together so map* only ever shows a complete query.
      S_DRAIN: begin
        map_l_d = stage_l_q;
        map_r_d = stage_r_q;
        map_b_d = stage_b_q;
        map_t_d = slot_code;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q     <= PTR_RST;
      x_q       <= '0;
      y_q       <= '0;
      s_q       <= '0;
      oob_q     <= 1'b0;
      stage_l_q <= '0;
      stage_r_q <= '0;
      stage_b_q <= '0;
      map_l_q   <= '0;
      map_r_q   <= '0;
      map_b_q   <= '0;
      map_t_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      s_q       <= s_d;
      oob_q     <= oob_d;
      stage_l_q <= stage_l_d;
      stage_r_q <= stage_r_d;
      stage_b_q <= stage_b_d;
      map_l_q   <= map_l_d;
      map_r_q   <= map_r_d;
      map_b_q   <= map_b_d;
      map_t_q   <= map_t_d;
    end
  end

endmodule
`default_nettype wire
